// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream in, instruction-memory write port out
interface imem_loader_if;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  modport master(input rx_data, rx_valid, output rx_ready, imem_we, imem_waddr, imem_wdata);
  modport slave(output rx_data, rx_valid, input rx_ready, imem_we, imem_waddr, imem_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader that writes instruction memory and gates core reset
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int MAX_WORDS = 256
) (
  input logic clk,
  input logic reset,
  input logic start,
  imem_loader_if.master bus,
  output logic cpu_reset_hold,
  output logic busy,
  output logic done,
  output logic error
);
  localparam int IW = $clog2(MAX_WORDS);
  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR} state_t;
  state_t state, state_nxt;
  logic [15:0] len;
  logic [15:0] len_in;
  logic [1:0] byte_idx;
  logic [IW-1:0] word_idx;
  logic [7:0] chk;
  logic [31:0] word;
  logic xfer;
  logic last;
  logic launch;
  assign xfer = bus.rx_valid & bus.rx_ready;
  assign last = 16'(word_idx) == len - 16'd1;
  assign launch = start & (state == IDLE | state == DONE | state == ERROR);
  assign len_in = {bus.rx_data, len[7:0]};
  assign bus.rx_ready = state inside {LEN_LO, LEN_HI, DATA, CHECK};
  assign bus.imem_we = state == WRITE;
  assign bus.imem_waddr = BASE_ADDR + 32'({word_idx, 2'b00});
  assign bus.imem_wdata = word;
  assign busy = state inside {LEN_LO, LEN_HI, DATA, WRITE, CHECK};
  assign done = state == DONE;
  assign error = state == ERROR;
  assign cpu_reset_hold = state != DONE;
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: state_nxt = launch ? LEN_LO : state;
      LEN_LO: state_nxt = xfer ? LEN_HI : state;
      LEN_HI: state_nxt = !xfer ? state : (len_in == 16'd0 || len_in > MAX_LEN) ? ERROR : DATA;
      DATA: state_nxt = (xfer && byte_idx == 2'd3) ? WRITE : state;
      WRITE: state_nxt = last ? CHECK : DATA;
      CHECK: state_nxt = !xfer ? state : (bus.rx_data == chk) ? DONE : ERROR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      len <= '0;
      byte_idx <= '0;
      word_idx <= '0;
      chk <= '0;
      word <= '0;
    end else begin
      if (launch) begin
        byte_idx <= '0;
        word_idx <= '0;
        chk <= '0;
      end
      if (xfer && state == LEN_LO) len[7:0] <= bus.rx_data;
      if (xfer && state == LEN_HI) len[15:8] <= bus.rx_data;
      if (xfer && state == DATA) begin
        word[8*byte_idx +: 8] <= bus.rx_data;
        chk <= chk ^ bus.rx_data;
        byte_idx <= byte_idx + 2'd1;
      end
      if (state == WRITE && !last) word_idx <= word_idx + IW'(1);
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized load streams checked against a write-list reference model
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int MAXW = 256;
  logic clk = 0;
  logic reset = 1;
  logic start = 0;
  logic cpu_reset_hold;
  logic busy;
  logic done;
  logic error;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] stim[$];
  logic [63:0] writes[$];
  imem_loader_if bus();
  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bus(bus),
    .cpu_reset_hold(cpu_reset_hold),
    .busy(busy),
    .done(done),
    .error(error)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      writes.push_back({bus.imem_waddr, bus.imem_wdata});
      check("rx_ready_in_write", 64'(bus.rx_ready), 64'd0);
    end
  end
  function automatic logic [7:0] xor_chk();
    logic [7:0] r = 8'h00;
    foreach (stim[i]) r ^= stim[i][7:0] ^ stim[i][15:8] ^ stim[i][23:16] ^ stim[i][31:24];
    return r;
  endfunction
  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
    int n = 0;
    bit ok = 0;
    repeat ($urandom_range(gap, 0)) begin
      bus.rx_valid = 0;
      bus.rx_data = 8'($urandom);
      start = noise && ($urandom_range(3, 0) == 0);
      @(posedge clk);
      #1;
    end
    start = 0;
    bus.rx_valid = 1;
    bus.rx_data = b;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = bus.rx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.rx_valid = 0;
    if (!ok) check("rx_timeout", 64'd0, 64'd1);
  endtask
  task automatic pulse_start();
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask
  task automatic run_load(input string tag, input logic [15:0] len, input logic [7:0] chk_byte, input int gap, input bit noise);
    bit len_ok = len != 16'd0 && int'(len) <= MAXW;
    bit exp_done = len_ok && chk_byte == xor_chk();
    int exp_n = len_ok ? int'(len) : 0;
    writes.delete();
    pulse_start();
    @(negedge clk);
    check({tag, "_busy_start"}, 64'(busy), 64'd1);
    check({tag, "_hold_start"}, 64'(cpu_reset_hold), 64'd1);
    @(posedge clk);
    #1;
    send_byte(len[7:0], gap, noise);
    send_byte(len[15:8], gap, noise);
    if (len_ok) begin
      for (int i = 0; i < exp_n; i++)
        for (int b = 0; b < 4; b++) send_byte(stim[i][8*b +: 8], gap, noise);
      send_byte(chk_byte, gap, noise);
    end
    @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'(exp_done));
    check({tag, "_error"}, 64'(error), 64'(!exp_done));
    check({tag, "_hold"}, 64'(cpu_reset_hold), 64'(!exp_done));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_nwrites"}, 64'(writes.size()), 64'(exp_n));
    for (int i = 0; i < exp_n && i < writes.size(); i++)
      check({tag, "_write"}, writes[i], {BASE + 32'(4 * i), stim[i]});
    @(posedge clk);
    #1;
  endtask
  task automatic rand_stim(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back($urandom);
  endtask
  initial begin
    bus.rx_valid = 0;
    bus.rx_data = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("idle_hold", 64'(cpu_reset_hold), 64'd1);
    check("idle_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("idle_we", 64'(bus.imem_we), 64'd0);
    check("idle_done", 64'(done), 64'd0);
    check("idle_error", 64'(error), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_nwrites", 64'(writes.size()), 64'd0);
    @(posedge clk);
    #1;
    stim = '{32'h0000_0513, 32'h0000_006F};
    run_load("good", 16'd2, xor_chk(), 0, 0);
    run_load("badchk", 16'd2, 8'h12, 0, 0);
    run_load("len0", 16'h0000, 8'h00, 0, 0);
    run_load("len257", 16'h0101, 8'h00, 0, 0);
    run_load("good_noise", 16'd2, xor_chk(), 4, 1);
    writes.delete();
    pulse_start();
    send_byte(8'h02, 0, 0);
    send_byte(8'h00, 0, 0);
    for (int k = 0; k < 5; k++) send_byte(stim[k / 4][8*(k % 4) +: 8], 0, 0);
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("rst_hold", 64'(cpu_reset_hold), 64'd1);
    bus.rx_valid = 1;
    repeat (10) @(posedge clk);
    #1;
    bus.rx_valid = 0;
    check("rst_nwrites", 64'(writes.size()), 64'd1);
    check("rst_first_write", writes[0], {BASE, stim[0]});
    run_load("restart", 16'd2, xor_chk(), 2, 0);
    rand_stim(1);
    run_load("len1", 16'd1, xor_chk(), 0, 0);
    rand_stim(MAXW);
    run_load("len_max", 16'(MAXW), xor_chk(), 0, 0);
    for (int t = 0; t < 6; t++) begin
      rand_stim($urandom_range(8, 1));
      run_load("rand", 16'(stim.size()), ($urandom_range(1, 0) == 1) ? xor_chk() : xor_chk() ^ 8'($urandom_range(255, 1)), 3, 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
